video_out_read: RTL and testbench

Wishbone master that fetches a stored frame from RAM and feeds it, 32-bit word by word, into the output-side pixel FIFO of the video-out path. It is the read counterpart of the video-in store stage: the processor writes a frame base address into the control registers, the block reads `P_WIDTH*P_HEIGHT` bytes (4 pixels per word) in packets of `NB_PACK` words, and it raises `interrupt` when the frame has been fully fetched.

---
 rtl/video_out_read.sv | 162 ++++++++++++++++
 tb/tb_video_out_read.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_read.sv
// Wishbone read master that streams a stored frame from RAM into the video-out pixel FIFO.
// Optional `VIDEO_OUT_READ_LOCK_EN keeps CYC/LOCK asserted across each packet.
module video_out_read #(
    parameter int P_WIDTH  = 640,
    parameter int P_HEIGHT = 480,
    parameter int NB_PACK  = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_room,
    output logic        w_req,
    output logic [31:0] data_out,
    output logic        interrupt,
    output logic        new_addr,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    output logic [2:0]  dbg_state_o
);

    localparam int PACK_W = $clog2(NB_PACK + 1);
    localparam logic [PACK_W-1:0] PACK_FULL = PACK_W'(NB_PACK);
    localparam logic [19:0] FRAME_END = 20'(P_WIDTH * P_HEIGHT);

    typedef enum logic [2:0] {
        WAIT_ADDR  = 3'd0,
        WAIT_ROOM  = 3'd1,
        READ       = 3'd2,
        BREAK      = 3'd3,
        FRAME_DONE = 3'd4
    } state_t;

    state_t             state_q;
    logic [31:0]        base_q;
    logic [19:0]        offset_q;
    logic [PACK_W-1:0]  pack_cnt_q;
    logic [1:0]         int_cnt_q;
    logic               ctr0_q;
    logic               stb_q;
    logic               cyc_q;
    logic               w_req_q;
    logic               int_q;
    logic [31:0]        adr_q;
    logic [31:0]        data_q;

    logic [19:0]        offset_d;
    logic [PACK_W-1:0]  pack_cnt_d;
    logic [31:0]        adr_d;

`ifdef VIDEO_OUT_READ_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
    assign p_wb_LOCK_O = cyc_q;
`else
    localparam bit LOCK_EN = 1'b0;
    assign p_wb_LOCK_O = 1'b0;
`endif

    assign offset_d   = offset_q + 20'd4;
    assign pack_cnt_d = pack_cnt_q - PACK_W'(1);
    assign adr_d      = base_q + {12'd0, offset_q};

    assign new_addr    = wb_reg_ctr[0] & ~ctr0_q;
    assign w_req       = w_req_q;
    assign data_out    = data_q;
    assign interrupt   = int_q;
    assign p_wb_STB_O  = stb_q;
    assign p_wb_CYC_O  = cyc_q;
    assign p_wb_WE_O   = 1'b0;
    assign p_wb_SEL_O  = 4'hf;
    assign p_wb_ADR_O  = adr_q;
    assign dbg_state_o = state_q;

    logic unused_ctr;
    assign unused_ctr = ^wb_reg_ctr[31:1];

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q    <= WAIT_ADDR;
            base_q     <= '0;
            offset_q   <= '0;
            pack_cnt_q <= PACK_FULL;
            int_cnt_q  <= '0;
            ctr0_q     <= 1'b0;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
            w_req_q    <= 1'b0;
            int_q      <= 1'b0;
            adr_q      <= '0;
            data_q     <= '0;
        end else begin
            ctr0_q  <= wb_reg_ctr[0];
            w_req_q <= 1'b0;
            case (state_q)
                WAIT_ADDR: begin
                    base_q   <= wb_reg_data;
                    offset_q <= '0;
                    int_q    <= 1'b0;
                    stb_q    <= 1'b0;
                    cyc_q    <= 1'b0;
                    if (new_addr) state_q <= WAIT_ROOM;
                end
                WAIT_ROOM: begin
                    stb_q      <= 1'b0;
                    cyc_q      <= 1'b0;
                    pack_cnt_q <= PACK_FULL;
                    if (fifo_room) begin
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        adr_q   <= adr_d;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // An error wins over a simultaneous ACK; offset is kept so the word is retried.
                    if (p_wb_ERR_I) begin
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        state_q <= BREAK;
                    end else if (p_wb_ACK_I) begin
                        data_q     <= p_wb_DAT_I;
                        w_req_q    <= 1'b1;
                        offset_q   <= offset_d;
                        pack_cnt_q <= pack_cnt_d;
                        stb_q      <= 1'b0;
                        cyc_q      <= LOCK_EN && (pack_cnt_d != '0);
                        state_q    <= BREAK;
                    end
                end
                BREAK: begin
                    stb_q <= 1'b0;
                    cyc_q <= 1'b0;
                    if (offset_q == FRAME_END) begin
                        state_q <= FRAME_DONE;
                    end else if (pack_cnt_q == '0) begin
                        state_q <= WAIT_ROOM;
                    end else begin
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        adr_q   <= adr_d;
                        state_q <= READ;
                    end
                end
                FRAME_DONE: begin
                    // Four FRAME_DONE cycles plus the first WAIT_ADDR cycle give a 4-cycle pulse.
                    int_q     <= 1'b1;
                    int_cnt_q <= int_cnt_q + 2'd1;
                    if (int_cnt_q == 2'd3) state_q <= WAIT_ADDR;
                end
                default: state_q <= WAIT_ADDR;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_read.sv
// Directed bench for video_out_read with an 8x2 frame and 2-word packets.
module tb_video_out_read;

    logic        clk;
    logic        nRST;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic        fifo_room;
    logic        w_req;
    logic [31:0] data_out;
    logic        interrupt;
    logic        new_addr;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic        p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    logic [2:0]  dbg_state_o;

`ifdef VIDEO_OUT_READ_LOCK_EN
    localparam logic LOCK_EXP = 1'b1;
`else
    localparam logic LOCK_EXP = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    // Slave model: data is the address xor a tag; wait states and one-shot errors are configurable.
    int          wait_states = 0;
    int          wait_cnt    = 0;
    logic        ack_force   = 1'b0;
    logic [31:0] err_adr     = 32'hFFFF_FFFF;
    int          err_allow   = 0;
    int          err_hits    = 0;

    logic [31:0] acc_q[$];
    logic [31:0] err_q[$];
    logic [31:0] dat_q[$];

    assign p_wb_DAT_I = p_wb_ADR_O ^ 32'hA5A5_0000;
    assign p_wb_ERR_I = p_wb_STB_O && (p_wb_ADR_O == err_adr) && (err_hits < err_allow);
    assign p_wb_ACK_I = ack_force || (p_wb_STB_O && (wait_cnt >= wait_states));

    video_out_read #(.P_WIDTH(8), .P_HEIGHT(2), .NB_PACK(2)) dut (
        .clk(clk), .nRST(nRST), .wb_reg_ctr(wb_reg_ctr), .wb_reg_data(wb_reg_data),
        .fifo_room(fifo_room), .w_req(w_req), .data_out(data_out), .interrupt(interrupt),
        .new_addr(new_addr), .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O),
        .p_wb_LOCK_O(p_wb_LOCK_O), .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O),
        .p_wb_ADR_O(p_wb_ADR_O), .p_wb_DAT_I(p_wb_DAT_I), .p_wb_ACK_I(p_wb_ACK_I),
        .p_wb_ERR_I(p_wb_ERR_I), .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        wait_cnt <= (p_wb_STB_O && !p_wb_ACK_I && !p_wb_ERR_I) ? wait_cnt + 1 : 0;
        if (p_wb_STB_O && p_wb_ERR_I) err_hits <= err_hits + 1;
    end

    always @(negedge clk) begin
        if (p_wb_STB_O && p_wb_ACK_I && !p_wb_ERR_I) acc_q.push_back(p_wb_ADR_O);
        if (p_wb_STB_O && p_wb_ERR_I) err_q.push_back(p_wb_ADR_O);
        if (w_req) dat_q.push_back(data_out);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        err_q.delete();
        dat_q.delete();
    endtask

    task automatic start_frame(input logic [31:0] base);
        wb_reg_ctr  = 32'd0;
        wb_reg_data = base;
        step();
        wb_reg_ctr  = 32'd1;
    endtask

    // Waits for the interrupt and returns how many consecutive cycles it stayed high.
    task automatic wait_int(output int high);
        int n;
        high = 0;
        n = 0;
        @(negedge clk);
        while (!interrupt && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (interrupt && high < 20) begin
            high++;
            @(negedge clk);
        end
    endtask

    task automatic check_adrs(input string tag, input logic [31:0] exp[4]);
        check({tag, "_count"}, 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check(tag, (i < acc_q.size()) ? acc_q[i] : 32'hxxxx_xxxx, exp[i]);
    endtask

    task automatic check_data(input string tag, input logic [31:0] exp[4]);
        check({tag, "_count"}, 32'(dat_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check(tag, (i < dat_q.size()) ? dat_q[i] : 32'hxxxx_xxxx, exp[i]);
    endtask

    initial begin
        logic [31:0] adr_1000[4];
        logic [31:0] dat_1000[4];
        logic [31:0] adr_2000[4];
        int          high;
        int          n;
        int          stb_seen;

        adr_1000 = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        dat_1000 = '{32'hA5A5_1000, 32'hA5A5_1004, 32'hA5A5_1008, 32'hA5A5_100C};
        adr_2000 = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};

        nRST        = 1'b0;
        wb_reg_ctr  = 32'd0;
        wb_reg_data = 32'd0;
        fifo_room   = 1'b1;
        repeat (3) step();
        check("rst_stb", {31'd0, p_wb_STB_O}, 32'd0);
        check("rst_cyc", {31'd0, p_wb_CYC_O}, 32'd0);
        check("rst_lock", {31'd0, p_wb_LOCK_O}, 32'd0);
        check("rst_we", {31'd0, p_wb_WE_O}, 32'd0);
        check("rst_sel", {28'd0, p_wb_SEL_O}, 32'hF);
        check("rst_wreq", {31'd0, w_req}, 32'd0);
        check("rst_int", {31'd0, interrupt}, 32'd0);
        check("rst_adr", p_wb_ADR_O, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_state", {29'd0, dbg_state_o}, 32'd0);
        nRST = 1'b1;
        step();

        // Frame 1: exact cycle timing at the start of the frame.
        clear_logs();
        wb_reg_data = 32'h1000;
        wb_reg_ctr  = 32'd1;
        #1;
        check("new_addr_pulse", {31'd0, new_addr}, 32'd1);
        step();
        check("t1_state_room", {29'd0, dbg_state_o}, 32'd1);
        check("t1_new_addr_low", {31'd0, new_addr}, 32'd0);
        check("t1_stb_e1", {31'd0, p_wb_STB_O}, 32'd0);
        step();
        check("t1_stb_e2", {31'd0, p_wb_STB_O}, 32'd1);
        check("t1_cyc_e2", {31'd0, p_wb_CYC_O}, 32'd1);
        check("t1_adr_e2", p_wb_ADR_O, 32'h1000);
        step();
        check("t1_wreq_e3", {31'd0, w_req}, 32'd1);
        check("t1_data_e3", data_out, 32'hA5A5_1000);
        check("t1_stb_e3", {31'd0, p_wb_STB_O}, 32'd0);
        check("t1_cyc_break_mid", {31'd0, p_wb_CYC_O}, {31'd0, LOCK_EXP});
        check("t1_lock_break_mid", {31'd0, p_wb_LOCK_O}, {31'd0, LOCK_EXP});
        step();
        check("t1_wreq_e4", {31'd0, w_req}, 32'd0);
        check("t1_stb_e4", {31'd0, p_wb_STB_O}, 32'd1);
        check("t1_adr_e4", p_wb_ADR_O, 32'h1004);
        step();
        check("t1_data_e5", data_out, 32'hA5A5_1004);
        check("t1_cyc_break_end", {31'd0, p_wb_CYC_O}, 32'd0);
        check("t1_lock_break_end", {31'd0, p_wb_LOCK_O}, 32'd0);
        wait_int(high);
        check("t1_int_len", 32'(high), 32'd4);
        check_adrs("t1_adr", adr_1000);
        check_data("t1_dat", dat_1000);
        check("t1_state_idle", {29'd0, dbg_state_o}, 32'd0);

        // Frame 2: FIFO full after the first packet stalls the fetch.
        clear_logs();
        start_frame(32'h1000);
        n = 0;
        @(negedge clk);
        while (acc_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        fifo_room = 1'b0;
        repeat (6) step();
        stb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (p_wb_STB_O) stb_seen++;
        end
        check("t2_stall_stb", 32'(stb_seen), 32'd0);
        check("t2_stall_state", {29'd0, dbg_state_o}, 32'd1);
        check("t2_stall_reads", 32'(acc_q.size()), 32'd2);
        fifo_room = 1'b1;
        wait_int(high);
        check("t2_int_len", 32'(high), 32'd4);
        check_adrs("t2_adr", adr_1000);

        // Frame 3: bus error on 0x1004 is retried without a FIFO write.
        clear_logs();
        err_adr   = 32'h1004;
        err_allow = err_hits + 1;
        start_frame(32'h1000);
        wait_int(high);
        check("t3_int_len", 32'(high), 32'd4);
        check("t3_err_count", 32'(err_q.size()), 32'd1);
        check("t3_err_adr", (err_q.size() > 0) ? err_q[0] : 32'hxxxx_xxxx, 32'h1004);
        check_adrs("t3_adr", adr_1000);
        check_data("t3_dat", dat_1000);
        err_adr = 32'hFFFF_FFFF;

        // Frame 4: a new address mid-frame is ignored; it takes effect only on a fresh edge.
        clear_logs();
        start_frame(32'h1000);
        step();
        wb_reg_ctr = 32'd0;
        n = 0;
        @(negedge clk);
        while (acc_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        wb_reg_data = 32'h2000;
        wb_reg_ctr  = 32'd1;
        wait_int(high);
        check("t4_int_len", 32'(high), 32'd4);
        check_adrs("t4_adr", adr_1000);
        stb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (p_wb_STB_O) stb_seen++;
        end
        check("t4_no_restart", 32'(stb_seen), 32'd0);
        clear_logs();
        start_frame(32'h2000);
        wait_int(high);
        check_adrs("t4_adr_new", adr_2000);
        check("t4_first_data", (dat_q.size() > 0) ? dat_q[0] : 32'hxxxx_xxxx, 32'hA5A5_2000);

        // Frame 5: reset while a 3-wait-state read is outstanding; the late ACK is dropped.
        clear_logs();
        wait_states = 3;
        start_frame(32'h1000);
        n = 0;
        @(negedge clk);
        while (!p_wb_STB_O && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_stb_before_rst", {31'd0, p_wb_STB_O}, 32'd1);
        nRST       = 1'b0;
        wb_reg_ctr = 32'd0;
        step();
        check("t5_rst_stb", {31'd0, p_wb_STB_O}, 32'd0);
        check("t5_rst_cyc", {31'd0, p_wb_CYC_O}, 32'd0);
        check("t5_rst_adr", p_wb_ADR_O, 32'd0);
        check("t5_rst_data", data_out, 32'd0);
        check("t5_rst_state", {29'd0, dbg_state_o}, 32'd0);
        nRST      = 1'b1;
        ack_force = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (w_req) n++;
        end
        ack_force = 1'b0;
        check("t5_late_ack_wreq", 32'(n), 32'd0);
        check("t5_late_ack_log", 32'(dat_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
